// File: rtl/spi_slave_sync_if.sv
// Pin bundle between the clock-domain SPI responder and the logic that drives
// or observes it: serial lines, commit strobes and the local read port.
interface spi_slave_sync_if #(
    parameter int AWIDTH = 4,
    parameter int DWIDTH = 8
);
    logic [1:0]        spi_mode;
    logic              sck;
    logic              mosi;
    logic              ss_n;
    logic              miso;
    logic              miso_oe;
    logic              wr_valid;
    logic [AWIDTH-1:0] wr_addr;
    logic [DWIDTH-1:0] wr_data;
    logic              rd_valid;
    logic              frame_err;
    logic [AWIDTH-1:0] loc_addr;
    logic [DWIDTH-1:0] loc_rdata;

    modport slave (
        input  spi_mode, sck, mosi, ss_n, loc_addr,
        output miso, miso_oe, wr_valid, wr_addr, wr_data,
        output rd_valid, frame_err, loc_rdata
    );

    modport master (
        output spi_mode, sck, mosi, ss_n, loc_addr,
        input  miso, miso_oe, wr_valid, wr_addr, wr_data,
        input  rd_valid, frame_err, loc_rdata
    );
endinterface

// File: rtl/spi_slave_sync.sv
// SPI responder that oversamples sck/mosi/ss_n on clk, decodes {R/W, addr, data}
// frames in all four SPI modes and serves a small register file.
module spi_slave_sync #(
    parameter int AWIDTH = 4,
    parameter int DWIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    spi_slave_sync_if.slave  bus
);
    localparam int F     = 1 + AWIDTH + DWIDTH;
    localparam int CW    = $clog2(F + 1);
    localparam int DEPTH = 2 ** AWIDTH;

    typedef enum logic [2:0] {IDLE, CMD, ADDR, DATA, DONE} state_t;

    logic              sck_s1_reg, sck_s2_reg, sck_prev_reg;
    logic              mosi_s1_reg, mosi_s2_reg;
    logic              ss_s1_reg, ss_s2_reg, ss_prev_reg;
    logic [1:0]        fill_reg;
    logic              ss_armed_reg;

    state_t            state_reg;
    logic              cpol_reg, cpha_reg, rw_reg;
    logic [CW-1:0]     bit_cnt_reg;
    logic [AWIDTH-1:0] addr_reg;
    logic [DWIDTH-1:0] data_reg;
    logic [DWIDTH-1:0] tx_reg;
    logic              tx_loaded_reg;
    logic              miso_reg, miso_oe_reg;
    logic              wr_valid_reg, rd_valid_reg, frame_err_reg;
    logic [AWIDTH-1:0] wr_addr_reg;
    logic [DWIDTH-1:0] wr_data_reg;
    logic [DWIDTH-1:0] regfile_reg [DEPTH];

    logic              sck_rise, sck_fall, sample_on_rise;
    logic              sample_edge, shift_edge;
    logic              ss_fall, ss_rise, commit;
    logic [AWIDTH-1:0] addr_shift;
    logic [DWIDTH-1:0] data_shift;

    // fill_reg marks when the ss_n synchronizer holds a real sample rather than
    // its reset value, so a reset under a held-low ss_n cannot fake a falling edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sck_s1_reg   <= 1'b0;
            sck_s2_reg   <= 1'b0;
            sck_prev_reg <= 1'b0;
            mosi_s1_reg  <= 1'b0;
            mosi_s2_reg  <= 1'b0;
            ss_s1_reg    <= 1'b1;
            ss_s2_reg    <= 1'b1;
            ss_prev_reg  <= 1'b1;
            fill_reg     <= 2'b00;
            ss_armed_reg <= 1'b0;
        end else begin
            sck_s1_reg   <= bus.sck;
            sck_s2_reg   <= sck_s1_reg;
            sck_prev_reg <= sck_s2_reg;
            mosi_s1_reg  <= bus.mosi;
            mosi_s2_reg  <= mosi_s1_reg;
            ss_s1_reg    <= bus.ss_n;
            ss_s2_reg    <= ss_s1_reg;
            ss_prev_reg  <= ss_s2_reg;
            fill_reg     <= {fill_reg[0], 1'b1};
            if (fill_reg[1] && ss_s2_reg)
                ss_armed_reg <= 1'b1;
        end
    end

    assign sck_rise       = sck_s2_reg & ~sck_prev_reg;
    assign sck_fall       = ~sck_s2_reg & sck_prev_reg;
    // Modes 0 and 3 sample on rise, modes 1 and 2 on fall.
    assign sample_on_rise = (cpol_reg == cpha_reg);
    assign sample_edge    = sample_on_rise ? sck_rise : sck_fall;
    assign shift_edge     = sample_on_rise ? sck_fall : sck_rise;
    assign ss_fall        = ss_armed_reg & ss_prev_reg & ~ss_s2_reg;
    assign ss_rise        = ~ss_prev_reg & ss_s2_reg;
    assign addr_shift     = AWIDTH'({addr_reg, mosi_s2_reg});
    assign data_shift     = DWIDTH'({data_reg, mosi_s2_reg});
    assign commit         = sample_edge & ~ss_rise & (state_reg == DATA) & ~rw_reg
                          & (bit_cnt_reg == CW'(F - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++)
                regfile_reg[i] <= '0;
        end else if (commit) begin
            regfile_reg[addr_reg] <= data_shift;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= IDLE;
            cpol_reg      <= 1'b0;
            cpha_reg      <= 1'b0;
            rw_reg        <= 1'b0;
            bit_cnt_reg   <= '0;
            addr_reg      <= '0;
            data_reg      <= '0;
            tx_reg        <= '0;
            tx_loaded_reg <= 1'b0;
            miso_reg      <= 1'b0;
            miso_oe_reg   <= 1'b0;
            wr_valid_reg  <= 1'b0;
            rd_valid_reg  <= 1'b0;
            frame_err_reg <= 1'b0;
            wr_addr_reg   <= '0;
            wr_data_reg   <= '0;
        end else begin
            wr_valid_reg  <= 1'b0;
            rd_valid_reg  <= 1'b0;
            frame_err_reg <= 1'b0;
            // Deselect beats any sck edge seen in the same cycle.
            if (ss_rise && state_reg != IDLE) begin
                if (state_reg != DONE)
                    frame_err_reg <= 1'b1;
                state_reg     <= IDLE;
                miso_reg      <= 1'b0;
                miso_oe_reg   <= 1'b0;
                tx_loaded_reg <= 1'b0;
            end else begin
                case (state_reg)
                    IDLE: begin
                        if (ss_fall) begin
                            cpol_reg      <= bus.spi_mode[1];
                            cpha_reg      <= bus.spi_mode[0];
                            rw_reg        <= 1'b0;
                            bit_cnt_reg   <= '0;
                            addr_reg      <= '0;
                            data_reg      <= '0;
                            tx_reg        <= '0;
                            tx_loaded_reg <= 1'b0;
                            miso_reg      <= 1'b0;
                            miso_oe_reg   <= 1'b1;
                            state_reg     <= CMD;
                        end
                    end
                    CMD: begin
                        if (sample_edge) begin
                            rw_reg      <= mosi_s2_reg;
                            bit_cnt_reg <= bit_cnt_reg + CW'(1);
                            state_reg   <= ADDR;
                        end
                    end
                    ADDR: begin
                        if (sample_edge) begin
                            addr_reg    <= addr_shift;
                            bit_cnt_reg <= bit_cnt_reg + CW'(1);
                            if (bit_cnt_reg == CW'(AWIDTH)) begin
                                state_reg <= DATA;
                                if (rw_reg) begin
                                    tx_reg        <= regfile_reg[addr_shift];
                                    tx_loaded_reg <= 1'b1;
                                end
                            end
                        end
                    end
                    DATA: begin
                        if (sample_edge) begin
                            bit_cnt_reg <= bit_cnt_reg + CW'(1);
                            if (!rw_reg)
                                data_reg <= data_shift;
                            if (bit_cnt_reg == CW'(F - 1)) begin
                                state_reg <= DONE;
                                if (rw_reg) begin
                                    rd_valid_reg <= 1'b1;
                                end else begin
                                    wr_valid_reg <= 1'b1;
                                    wr_addr_reg  <= addr_reg;
                                    wr_data_reg  <= data_shift;
                                end
                            end
                        end else if (shift_edge && tx_loaded_reg) begin
                            miso_reg <= tx_reg[DWIDTH-1];
                            tx_reg   <= tx_reg << 1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.miso      = miso_reg & miso_oe_reg;
    assign bus.miso_oe   = miso_oe_reg;
    assign bus.wr_valid  = wr_valid_reg;
    assign bus.wr_addr   = wr_addr_reg;
    assign bus.wr_data   = wr_data_reg;
    assign bus.rd_valid  = rd_valid_reg;
    assign bus.frame_err = frame_err_reg;
    assign bus.loc_rdata = regfile_reg[bus.loc_addr];

endmodule

// File: tb/tb_spi_slave_sync.sv
// Bench for spi_slave_sync: an SPI master task drives frames in all modes, a
// scoreboard queue holds expected commits and read data.
module tb_spi_slave_sync;
    localparam int HALF = 50;

    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;
    int   wr_cnt;
    int   rd_cnt;
    int   err_cnt;
    logic [11:0] wr_q[$];
    logic [7:0]  rd_q[$];

    spi_slave_sync_if #(.AWIDTH(4), .DWIDTH(8)) bus ();

    spi_slave_sync #(.AWIDTH(4), .DWIDTH(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Scoreboard side: every commit strobe must match the oldest expected write.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.wr_valid) begin
                wr_cnt++;
                if (wr_q.size() == 0) begin
                    check("wr_unexpected", 32'd1, 32'd0);
                end else begin
                    logic [11:0] e;
                    e = wr_q.pop_front();
                    check("wr_addr", {28'd0, bus.wr_addr}, {28'd0, e[11:8]});
                    check("wr_data", {24'd0, bus.wr_data}, {24'd0, e[7:0]});
                    $display("[TB] write commit addr=0x%0h data=0x%0h", bus.wr_addr, bus.wr_data);
                end
            end
            if (bus.rd_valid)  rd_cnt++;
            if (bus.frame_err) err_cnt++;
        end
    end

    task automatic spi_frame(input logic [1:0] mode, input logic rw, input logic [3:0] addr,
                             input logic [7:0] wdata, input int ncyc, input bit release_ss,
                             output logic [7:0] rdata, output logic [4:0] pre);
        logic [12:0] frame;
        logic [15:0] rx;
        logic        cpol;
        logic        cpha;
        frame = {rw, addr, wdata};
        cpol  = mode[1];
        cpha  = mode[0];
        rx    = '0;
        bus.spi_mode = mode;
        bus.sck      = cpol;
        bus.mosi     = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        bus.ss_n = 1'b0;
        #(HALF);
        check("miso_oe_sel", {31'd0, bus.miso_oe}, 32'd1);
        for (int i = 0; i < ncyc; i++) begin
            logic b;
            b = (i < 13) ? frame[12-i] : 1'b0;
            if (!cpha) begin
                bus.mosi = b;
                #(HALF);
                bus.sck = ~cpol;
                rx = {rx[14:0], bus.miso};
                #(HALF);
                bus.sck = cpol;
            end else begin
                bus.sck  = ~cpol;
                bus.mosi = b;
                #(HALF);
                bus.sck = cpol;
                rx = {rx[14:0], bus.miso};
                #(HALF);
            end
        end
        rdata = (ncyc >= 13) ? 8'(rx >> (ncyc - 13)) : 8'd0;
        pre   = (ncyc >= 13) ? 5'(rx >> (ncyc - 5)) : 5'd0;
        #(HALF);
        if (release_ss) begin
            bus.ss_n = 1'b1;
            repeat (10) @(posedge clk);
            #2;
        end
        $display("[TB] frame mode=%0d rw=%0b addr=0x%0h wdata=0x%0h cycles=%0d miso_data=0x%0h",
                 mode, rw, addr, wdata, ncyc, rdata);
    endtask

    task automatic loc_check(input string tag, input logic [3:0] a, input logic [7:0] exp);
        bus.loc_addr = a;
        #1;
        check(tag, {24'd0, bus.loc_rdata}, {24'd0, exp});
    endtask

    initial begin
        logic [7:0] rd;
        logic [4:0] pre;
        int         w0;
        int         r0;
        n_tests = 0;
        n_fail  = 0;
        wr_cnt  = 0;
        rd_cnt  = 0;
        err_cnt = 0;
        rst          = 1'b1;
        bus.ss_n     = 1'b1;
        bus.sck      = 1'b0;
        bus.mosi     = 1'b0;
        bus.spi_mode = 2'd0;
        bus.loc_addr = 4'd0;
        repeat (3) @(posedge clk);
        #2;
        check("rst_miso",      {31'd0, bus.miso},      32'd0);
        check("rst_miso_oe",   {31'd0, bus.miso_oe},   32'd0);
        check("rst_wr_valid",  {31'd0, bus.wr_valid},  32'd0);
        check("rst_rd_valid",  {31'd0, bus.rd_valid},  32'd0);
        check("rst_frame_err", {31'd0, bus.frame_err}, 32'd0);
        check("rst_wr_addr",   {28'd0, bus.wr_addr},   32'd0);
        check("rst_wr_data",   {24'd0, bus.wr_data},   32'd0);
        check("rst_loc_rdata", {24'd0, bus.loc_rdata}, 32'd0);
        rst = 1'b0;

        // Mode 0 write.
        wr_q.push_back({4'h3, 8'hA5});
        spi_frame(2'd0, 1'b0, 4'h3, 8'hA5, 13, 1'b1, rd, pre);
        check("t1_wr_cnt", wr_cnt, 1);
        check("t1_wr_addr_held", {28'd0, bus.wr_addr}, 32'h3);
        loc_check("t1_loc3", 4'h3, 8'hA5);

        // Mode 3 read of the same address.
        rd_q.push_back(8'hA5);
        spi_frame(2'd3, 1'b1, 4'h3, 8'h00, 13, 1'b1, rd, pre);
        check("t2_miso_data", {24'd0, rd}, {24'd0, rd_q.pop_front()});
        check("t2_miso_pre", {27'd0, pre}, 32'd0);
        check("t2_rd_cnt", rd_cnt, 1);
        check("t2_wr_cnt", wr_cnt, 1);
        loc_check("t2_loc3", 4'h3, 8'hA5);

        // Modes 1 and 2: write then read back.
        for (int m = 1; m <= 2; m++) begin
            r0 = rd_cnt;
            wr_q.push_back({4'hF, 8'h3C});
            spi_frame(2'(m), 1'b0, 4'hF, 8'h3C, 13, 1'b1, rd, pre);
            rd_q.push_back(8'h3C);
            spi_frame(2'(m), 1'b1, 4'hF, 8'h00, 13, 1'b1, rd, pre);
            check("t3_miso_data", {24'd0, rd}, {24'd0, rd_q.pop_front()});
            check("t3_rd_pulse", rd_cnt - r0, 1);
            loc_check("t3_locF", 4'hF, 8'h3C);
        end

        // Abort after 7 sampled bits.
        w0 = wr_cnt;
        spi_frame(2'd0, 1'b0, 4'h5, 8'hFF, 7, 1'b1, rd, pre);
        check("t4_frame_err", err_cnt, 1);
        check("t4_no_write", wr_cnt - w0, 0);
        loc_check("t4_loc5", 4'h5, 8'h00);
        wr_q.push_back({4'h5, 8'h42});
        spi_frame(2'd0, 1'b0, 4'h5, 8'h42, 13, 1'b1, rd, pre);
        check("t4_next_write", wr_cnt - w0, 1);
        loc_check("t4_loc5_after", 4'h5, 8'h42);

        // 16 sck cycles: extra bits must be ignored.
        w0 = wr_cnt;
        wr_q.push_back({4'h1, 8'h81});
        spi_frame(2'd0, 1'b0, 4'h1, 8'h81, 16, 1'b1, rd, pre);
        check("t5_one_write", wr_cnt - w0, 1);
        loc_check("t5_loc1", 4'h1, 8'h81);

        // Reset in the middle of a write's data phase.
        wr_q.push_back({4'h2, 8'h11});
        spi_frame(2'd0, 1'b0, 4'h2, 8'h11, 13, 1'b1, rd, pre);
        loc_check("t6_loc2_pre", 4'h2, 8'h11);
        w0 = wr_cnt;
        r0 = rd_cnt;
        spi_frame(2'd0, 1'b0, 4'h2, 8'h77, 9, 1'b0, rd, pre);
        rst = 1'b1;
        #1;
        check("t6_rst_miso_oe", {31'd0, bus.miso_oe}, 32'd0);
        check("t6_rst_miso", {31'd0, bus.miso}, 32'd0);
        check("t6_rst_wr_addr", {28'd0, bus.wr_addr}, 32'd0);
        check("t6_rst_wr_data", {24'd0, bus.wr_data}, 32'd0);
        loc_check("t6_rst_loc2", 4'h2, 8'h00);
        @(posedge clk);
        #2;
        rst = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        bus.mosi = 1'b1;
        for (int i = 0; i < 13; i++) begin
            #(HALF);
            bus.sck = 1'b1;
            #(HALF);
            bus.sck = 1'b0;
        end
        repeat (10) @(posedge clk);
        #2;
        check("t6_held_miso_oe", {31'd0, bus.miso_oe}, 32'd0);
        check("t6_held_no_write", wr_cnt - w0, 0);
        check("t6_held_no_read", rd_cnt - r0, 0);
        check("t6_held_no_err", err_cnt, 1);
        loc_check("t6_held_loc2", 4'h2, 8'h00);
        bus.ss_n = 1'b1;
        repeat (10) @(posedge clk);
        #2;
        wr_q.push_back({4'h2, 8'h5A});
        spi_frame(2'd0, 1'b0, 4'h2, 8'h5A, 13, 1'b1, rd, pre);
        check("t6_recover_write", wr_cnt - w0, 1);
        loc_check("t6_recover_loc2", 4'h2, 8'h5A);

        check("wr_q_drained", wr_q.size(), 0);
        check("rd_q_drained", rd_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/spi_slave_sync.md
Name: spi_slave_sync

Overview:
- Clock-domain SPI responder (slave) that answers frames issued by spi_master.
- Oversamples sck/mosi/ss_n on the system clock and decodes one frame: R/W bit, address, data.
- Holds a 2^AWIDTH x DWIDTH register file: writes update it, reads return it on miso.
- Exposes a local observation port and commit strobes for the bench and system.

Parameters:
AWIDTH, 4, address bits per frame; register file depth = 2^AWIDTH
DWIDTH, 8, data bits per frame and register width

Ports:
clk        in   1       system clock
rst        in   1       asynchronous reset, active-high
spi_mode   in   2       {CPOL,CPHA}; latched on each synchronized ss_n falling edge
sck        in   1       SPI clock from master, asynchronous
mosi       in   1       master-out data, asynchronous
ss_n       in   1       slave select, active-low, asynchronous
miso       out  1       slave-out data
miso_oe    out  1       1 while selected (synchronized ss_n low)
wr_valid   out  1       1-cycle pulse on write commit
wr_addr    out  AWIDTH  address of last commit; held until next commit
wr_data    out  DWIDTH  data of last commit; held until next commit
rd_valid   out  1       1-cycle pulse when a read frame completes
frame_err  out  1       1-cycle pulse when ss_n rises mid-frame
loc_addr   in   AWIDTH  local read address
loc_rdata  out  DWIDTH  combinational regfile[loc_addr]

Behaviour:
- Synchronizers: 2-FF on sck, mosi, ss_n; ss_n stages reset to 1, sck/mosi stages to 0.
- Edges: detected from synchronized sck vs. its previous value.
- Required ratio: sck period >= 8 clk periods.
- Frame: MSB first; bit 0 = R/W (1 = read); then AWIDTH address bits; then DWIDTH data bits.
- F = 1+AWIDTH+DWIDTH (13 at defaults).
- Edge roles, with CPOL/CPHA taken from the spi_mode latched at frame start:
  - CPHA=0: sample on the leading edge, shift on the trailing edge.
  - CPHA=1: shift on the leading edge, sample on the trailing edge.
  - Leading edge = first transition away from the CPOL idle level.
- Mode table: mode0 sample rise/shift fall; mode1 sample fall/shift rise; mode2 sample fall/shift rise; mode3 sample rise/shift fall.
- FSM:
  - IDLE: on synced ss_n falling edge, latch mode, clear bit_cnt and shift regs, go CMD.
  - CMD: sample the R/W bit, go ADDR.
  - ADDR: sample AWIDTH bits, then go DATA.
  - DATA, write: sample DWIDTH bits.
  - DATA, read: a tx shift reg loads regfile[addr] when the last address bit is sampled. The first shift edge after that drives the data MSB on miso; each later shift edge drives the next bit.
  - DONE: entered when the F-th bit is sampled. Further sck edges are ignored.
  - Any state: synced ss_n rising returns the FSM to IDLE.
- bit_cnt counts sampled bits 0..F-1 and does not wrap.
- Write commit, on sampling data bit F-1, in the same clk:
  - regfile[addr] <= data
  - wr_addr/wr_data updated
  - wr_valid pulses 1 cycle
- Read completion: rd_valid pulses 1 cycle when bit F-1 is sampled. The regfile is unchanged and mosi is ignored during DATA.
- miso:
  - 0 in IDLE, CMD, ADDR and DONE before the first data shift.
  - Holds the last data bit through DONE until ss_n rises.
  - Forced 0 whenever miso_oe = 0.
- Abort: ss_n rises before bit F-1 is sampled. Result: no write, no rd_valid, frame_err pulses 1 cycle, return to IDLE.
- Simultaneous events:
  - ss_n rise in the same clk as a sample edge: ss_n wins and the edge is ignored.
  - ss_n fall is only honored from IDLE.
- Reset (async, any time, including mid-frame):
  - All outputs 0.
  - Regfile cleared to 0; wr_addr/wr_data = 0.
  - FSM to IDLE.
  - A new frame requires a fresh synced ss_n falling edge, i.e. ss_n seen high first.
- loc_rdata reflects a write on the clk after commit.

Test Plan:
1. Mode0: write frame R/W=0, addr 0x3, data 0xA5 -> wr_valid pulse once, wr_addr=0x3, wr_data=0xA5; loc_addr=3 gives loc_rdata=0xA5.
2. Mode3: read frame addr 0x3 after test 1 -> miso shifts 1,0,1,0,0,1,0,1 on the 8 data bits; rd_valid pulse; regfile unchanged.
3. Modes 1 and 2: write 0x3C to addr 0xF, then read it back in the same mode -> read returns 0x3C; the master's spi_slv_data = 0x3C.
4. Write addr 0x5 data 0xFF, ss_n raised after 7 sampled bits -> frame_err pulse, no wr_valid, regfile[5] stays 0x00; the next full frame works normally.
5. Write frame with 16 sck cycles (3 extra) to addr 0x1 data 0x81 -> exactly one wr_valid, regfile[1]=0x81; extra bits ignored.
6. rst asserted mid-DATA of a write to addr 0x2 (after a prior write 0x11 there) -> all outputs 0, regfile[2]=0x00 immediately; ss_n held low after reset produces no activity until ss_n toggles high then low.
